rv32imf_apu_dispatcher: RTL and testbench

Parametrised dispatcher between the core's APU request/response interface and NUM_UNITS auxiliary functional units (FPU, divider, etc.).
- Routes each granted request to the unit the core selects.
- Tracks issue order, buffers out-of-order completions, and returns results to the core strictly in issue order.
- Generates a per-unit clock-enable, generalising the single FPU clock-gate enable to many units.

---
 rtl/rv32imf_apu_dispatcher_pkg.sv | 17 +
 rtl/rv32imf_apu_sync_fifo.sv | 52 +++++
 rtl/rv32imf_apu_dispatcher.sv | 151 +++++++++++++++
 tb/tb_rv32imf_apu_dispatcher.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32imf_apu_dispatcher_pkg.sv
// Shared types and helpers for the APU dispatcher slice.
package rv32imf_apu_dispatcher_pkg;

    localparam int unsigned MAX_UNITS    = 8;
    localparam int unsigned DEF_WIDTH    = 32;
    localparam int unsigned DEF_RFLAGS_W = 5;

    function automatic int unsigned unit_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [DEF_WIDTH-1:0]    rdata;
        logic [DEF_RFLAGS_W-1:0] rflags;
    } result_t;

endpackage

// File: rtl/rv32imf_apu_sync_fifo.sv
// Synchronous FIFO with occupancy count; power-of-2 depth, async active-high reset.
module rv32imf_apu_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/rv32imf_apu_dispatcher.sv
// In-order APU dispatcher for NUM_UNITS auxiliary units with per-unit clock enables.
// Optional stall counter port enabled by RV32IMF_APU_DISPATCHER_PERF_EN.
module rv32imf_apu_dispatcher
    import rv32imf_apu_dispatcher_pkg::*;
#(
    parameter int unsigned NUM_UNITS    = 2,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned NUM_OPERANDS = 3,
    parameter int unsigned OP_W         = 6,
    parameter int unsigned FLAGS_W      = 15,
    parameter int unsigned RFLAGS_W     = 5
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             apu_req_i,
    output logic                             apu_gnt_o,
    input  logic [unit_w(NUM_UNITS)-1:0]     apu_unit_i,
    input  logic [NUM_OPERANDS*WIDTH-1:0]    apu_operands_i,
    input  logic [OP_W-1:0]                  apu_op_i,
    input  logic [FLAGS_W-1:0]               apu_flags_i,
    output logic                             apu_rvalid_o,
    output logic [WIDTH-1:0]                 apu_rdata_o,
    output logic [RFLAGS_W-1:0]              apu_rflags_o,
    output logic                             apu_busy_o,
    output logic [NUM_UNITS-1:0]             unit_req_o,
    input  logic [NUM_UNITS-1:0]             unit_gnt_i,
    output logic [NUM_OPERANDS*WIDTH-1:0]    unit_operands_o,
    output logic [OP_W-1:0]                  unit_op_o,
    output logic [FLAGS_W-1:0]               unit_flags_o,
    input  logic [NUM_UNITS-1:0]             unit_rvalid_i,
    input  logic [NUM_UNITS*WIDTH-1:0]       unit_rdata_i,
    input  logic [NUM_UNITS*RFLAGS_W-1:0]    unit_rflags_i,
`ifdef RV32IMF_APU_DISPATCHER_PERF_EN
    output logic [31:0]                      perf_stall_cnt_o,
`endif
    output logic [NUM_UNITS-1:0]             unit_clk_en_o
);

    localparam int unsigned UW = unit_w(NUM_UNITS);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned RW = WIDTH + RFLAGS_W;

    logic [NUM_UNITS-1:0] sel, issue, res_push, res_pop, res_empty, head_sel;
    logic [UW-1:0]        head_unit;
    logic [RW-1:0]        res_head [NUM_UNITS];
    logic [RW-1:0]        head_entry;
    logic                 head_ready, retire;
    logic                 order_full, order_empty;
    logic [CW-1:0]        order_cnt_unused;
    logic [CW-1:0]        res_cnt_unused [NUM_UNITS];
    logic [NUM_UNITS-1:0] res_full_unused;
    logic [CW-1:0]        cnt_q [NUM_UNITS];
    logic [CW-1:0]        cnt_d [NUM_UNITS];

    // Out-of-range unit indices match no select bit, so they never request or grant.
    always_comb begin
        sel = '0;
        for (int unsigned u = 0; u < NUM_UNITS; u++) sel[u] = (apu_unit_i == UW'(u));
    end

    assign unit_req_o      = sel & {NUM_UNITS{apu_req_i & ~order_full}};
    assign issue           = unit_req_o & unit_gnt_i;
    assign apu_gnt_o       = |issue;
    assign unit_operands_o = apu_operands_i;
    assign unit_op_o       = apu_op_i;
    assign unit_flags_o    = apu_flags_i;
    assign apu_busy_o      = ~order_empty;

    rv32imf_apu_sync_fifo #(.WIDTH(UW), .DEPTH(DEPTH)) u_order (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (apu_gnt_o),
        .pop_i   (retire),
        .wdata_i (apu_unit_i),
        .rdata_o (head_unit),
        .count_o (order_cnt_unused),
        .full_o  (order_full),
        .empty_o (order_empty)
    );

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
        // Results with no outstanding operation (e.g. issued before a reset) are dropped.
        assign res_push[g] = unit_rvalid_i[g] & (cnt_q[g] != '0);

        rv32imf_apu_sync_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_res (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (res_push[g]),
            .pop_i   (res_pop[g]),
            .wdata_i ({unit_rdata_i[g*WIDTH +: WIDTH], unit_rflags_i[g*RFLAGS_W +: RFLAGS_W]}),
            .rdata_o (res_head[g]),
            .count_o (res_cnt_unused[g]),
            .full_o  (res_full_unused[g]),
            .empty_o (res_empty[g])
        );

        assign unit_clk_en_o[g] = unit_req_o[g] | (cnt_q[g] != '0) | ~res_empty[g];
    end

    always_comb begin
        head_sel   = '0;
        head_entry = '0;
        head_ready = 1'b0;
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            if (head_unit == UW'(u)) begin
                head_sel[u] = 1'b1;
                head_entry  = res_head[u];
                head_ready  = ~res_empty[u];
            end
        end
        retire  = ~order_empty & head_ready;
        res_pop = head_sel & {NUM_UNITS{retire}};
    end

    assign apu_rvalid_o                = retire;
    assign {apu_rdata_o, apu_rflags_o} = retire ? head_entry : '0;

    always_comb begin
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            cnt_d[u] = cnt_q[u];
            if (issue[u] && !res_push[u])      cnt_d[u] = cnt_q[u] + CW'(1);
            else if (!issue[u] && res_push[u]) cnt_d[u] = cnt_q[u] - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned u = 0; u < NUM_UNITS; u++) cnt_q[u] <= '0;
        end else begin
            for (int unsigned u = 0; u < NUM_UNITS; u++) cnt_q[u] <= cnt_d[u];
        end
    end

`ifdef RV32IMF_APU_DISPATCHER_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (apu_req_i && !apu_gnt_o && stall_q != '1) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign perf_stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_rv32imf_apu_dispatcher.sv
// Randomised self-checking bench for rv32imf_apu_dispatcher against an in-order issue/retire model.
module tb_rv32imf_apu_dispatcher;

    localparam int NU  = 3;
    localparam int DP  = 4;
    localparam int W   = 32;
    localparam int RFW = 5;
    localparam int MAXOPS = 2048;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            apu_req_i;
    logic            apu_gnt_o;
    logic [1:0]      apu_unit_i;
    logic [3*W-1:0]  apu_operands_i;
    logic [5:0]      apu_op_i;
    logic [14:0]     apu_flags_i;
    logic            apu_rvalid_o;
    logic [W-1:0]    apu_rdata_o;
    logic [RFW-1:0]  apu_rflags_o;
    logic            apu_busy_o;
    logic [NU-1:0]   unit_req_o;
    logic [NU-1:0]   unit_gnt_i;
    logic [3*W-1:0]  unit_operands_o;
    logic [5:0]      unit_op_o;
    logic [14:0]     unit_flags_o;
    logic [NU-1:0]   unit_rvalid_i;
    logic [NU*W-1:0] unit_rdata_i;
    logic [NU*RFW-1:0] unit_rflags_i;
    logic [NU-1:0]   unit_clk_en_o;
`ifdef RV32IMF_APU_DISPATCHER_PERF_EN
    logic [31:0]     perf_stall_cnt_o;
`endif

    rv32imf_apu_dispatcher #(
        .NUM_UNITS(NU), .DEPTH(DP), .WIDTH(W), .NUM_OPERANDS(3),
        .OP_W(6), .FLAGS_W(15), .RFLAGS_W(RFW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .apu_req_i(apu_req_i), .apu_gnt_o(apu_gnt_o), .apu_unit_i(apu_unit_i),
        .apu_operands_i(apu_operands_i), .apu_op_i(apu_op_i), .apu_flags_i(apu_flags_i),
        .apu_rvalid_o(apu_rvalid_o), .apu_rdata_o(apu_rdata_o), .apu_rflags_o(apu_rflags_o),
        .apu_busy_o(apu_busy_o),
        .unit_req_o(unit_req_o), .unit_gnt_i(unit_gnt_i),
        .unit_operands_o(unit_operands_o), .unit_op_o(unit_op_o), .unit_flags_o(unit_flags_o),
        .unit_rvalid_i(unit_rvalid_i), .unit_rdata_i(unit_rdata_i), .unit_rflags_i(unit_rflags_i),
`ifdef RV32IMF_APU_DISPATCHER_PERF_EN
        .perf_stall_cnt_o(perf_stall_cnt_o),
`endif
        .unit_clk_en_o(unit_clk_en_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: every accepted op gets an index; results leave strictly in index order.
    int          op_unit [MAXOPS];
    bit          op_ret  [MAXOPS];
    bit          op_av   [MAXOPS];
    logic [31:0] op_data [MAXOPS];
    logic [4:0]  op_fl   [MAXOPS];
    int          nissue = 0, nretire = 0, live_base = 0;
    logic [31:0] stall_m = 0;

    function automatic bit pend(input int u);
        for (int k = live_base; k < nissue; k++)
            if (op_unit[k] == u && !op_ret[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_in(input bit req, input int unit, input bit [NU-1:0] ug, input bit [NU-1:0] urv);
        apu_req_i      = req;
        apu_unit_i     = unit[1:0];
        unit_gnt_i     = ug;
        unit_rvalid_i  = urv;
        apu_operands_i = {$urandom, $urandom, $urandom};
        apu_op_i       = 6'($urandom);
        apu_flags_i    = 15'($urandom);
        for (int u = 0; u < NU; u++) begin
            unit_rdata_i[u*W +: W]      = $urandom;
            unit_rflags_i[u*RFW +: RFW] = 5'($urandom);
        end
    endtask

    // One clock: compare outputs to the model, then advance the model across the edge.
    task automatic tick();
        bit          full, egnt, erv;
        bit [NU-1:0] ereq, ece;
        logic [31:0] ed;
        logic [4:0]  ef;
        int          rk [NU];
        int          ui;
        #1;
        ui   = int'(apu_unit_i);
        full = (nissue - nretire) == DP;
        egnt = 1'b0;
        ereq = '0;
        if (apu_req_i && ui < NU && !full) begin
            ereq[ui] = 1'b1;
            egnt     = unit_gnt_i[ui];
        end
        erv = (nretire < nissue) && op_av[nretire];
        ed  = erv ? op_data[nretire] : 32'h0;
        ef  = erv ? op_fl[nretire] : 5'h0;
        for (int u = 0; u < NU; u++) begin
            ece[u] = ereq[u];
            for (int k = nretire; k < nissue; k++) if (op_unit[k] == u) ece[u] = 1'b1;
        end
        check("gnt",    apu_gnt_o,    egnt);
        check("ureq",   unit_req_o,   ereq);
        check("rvalid", apu_rvalid_o, erv);
        check("rdata",  apu_rdata_o,  ed);
        check("rflags", apu_rflags_o, ef);
        check("busy",   apu_busy_o,   nissue != nretire);
        check("clk_en", unit_clk_en_o, ece);
        check("bc_op",  {unit_op_o, unit_flags_o}, {apu_op_i, apu_flags_i});
        check("bc_opd", unit_operands_o[63:0], apu_operands_i[63:0]);
`ifdef RV32IMF_APU_DISPATCHER_PERF_EN
        check("perf", perf_stall_cnt_o, stall_m);
`endif
        for (int u = 0; u < NU; u++) begin
            rk[u] = -1;
            if (unit_rvalid_i[u]) begin
                for (int k = live_base; k < nissue; k++) begin
                    if (op_unit[k] == u && !op_ret[k]) begin
                        rk[u] = k;
                        break;
                    end
                end
            end
        end
        @(posedge clk_i);
        if (erv) nretire++;
        for (int u = 0; u < NU; u++) begin
            if (rk[u] >= 0) begin
                op_ret[rk[u]]  = 1'b1;
                op_av[rk[u]]   = 1'b1;
                op_data[rk[u]] = unit_rdata_i[u*W +: W];
                op_fl[rk[u]]   = unit_rflags_i[u*RFW +: RFW];
            end
        end
        if (egnt) begin
            op_unit[nissue] = ui;
            op_ret[nissue]  = 1'b0;
            op_av[nissue]   = 1'b0;
            nissue++;
        end
        if (apu_req_i && !egnt && stall_m != 32'hFFFF_FFFF) stall_m++;
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        set_in(1'b0, 0, '0, '0);
        #1;
        check("rst_gnt",    apu_gnt_o,     1'b0);
        check("rst_rvalid", apu_rvalid_o,  1'b0);
        check("rst_rdata",  {apu_rdata_o, apu_rflags_o}, '0);
        check("rst_busy",   apu_busy_o,    1'b0);
        check("rst_ureq",   unit_req_o,    '0);
        check("rst_clk_en", unit_clk_en_o, '0);
`ifdef RV32IMF_APU_DISPATCHER_PERF_EN
        check("rst_perf", perf_stall_cnt_o, 32'h0);
`endif
        nretire   = nissue;
        live_base = nissue;
        stall_m   = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic drain();
        bit [NU-1:0] urv;
        for (int c = 0; c < 100 && nretire < nissue; c++) begin
            for (int u = 0; u < NU; u++) urv[u] = pend(u);
            set_in(1'b0, 0, '1, urv);
            tick();
        end
        check("drain", 64'(nissue - nretire), 64'h0);
    endtask

    initial begin
        @(negedge clk_i);
        do_reset();

        // Single op to unit 0, result two cycles after issue, retired one cycle later.
        set_in(1'b1, 0, 3'b001, '0); tick();
        set_in(1'b0, 0, '0, '0);     tick();
        set_in(1'b0, 0, '0, 3'b001);
        unit_rdata_i[31:0] = 32'h3F80_0000;
        unit_rflags_i[4:0] = 5'h0;
        tick();
        set_in(1'b0, 0, '0, '0);
        #1 check("t1_data", apu_rdata_o, 32'h3F80_0000);
        tick();
        #1 check("t1_busy", apu_busy_o, 1'b0);

        // Slow unit 1 then fast unit 0: order must be 0xB then 0xA.
        set_in(1'b1, 1, '1, '0); tick();
        set_in(1'b1, 0, '1, '0); tick();
        set_in(1'b0, 0, '0, 3'b001); unit_rdata_i[31:0]  = 32'hA; tick();
        set_in(1'b0, 0, '0, 3'b010); unit_rdata_i[63:32] = 32'hB;
        #1 check("t2_hold", apu_rvalid_o, 1'b0);
        tick();
        set_in(1'b0, 0, '0, '0);
        #1 check("t2_first", apu_rdata_o, 32'hB);
        check("t2_clken0", unit_clk_en_o[0], 1'b1);
        tick();
        #1 check("t2_second", apu_rdata_o, 32'hA);
        tick();

        // Fill to DEPTH, then a blocked request until one op retires.
        for (int i = 0; i < DP; i++) begin
            set_in(1'b1, i % 2, '1, '0);
            tick();
        end
        set_in(1'b1, 0, '1, '0);
        #1 check("t3_full_gnt", apu_gnt_o, 1'b0);
        check("t3_full_req", unit_req_o, '0);
        tick();
        set_in(1'b1, 0, '1, 3'b001); tick();
        set_in(1'b1, 0, '1, '0);
        #1 check("t3_retire_blk", {apu_rvalid_o, apu_gnt_o}, 2'b10);
        tick();
        #1 check("t3_resume", apu_gnt_o, 1'b1);
        tick();
        drain();

        // Unit index beyond NUM_UNITS is never granted.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 3, '1, '0);
            #1 check("t4_oor", {apu_gnt_o, unit_req_o}, '0);
            tick();
        end

        // Reset with ops outstanding; late results must be dropped.
        set_in(1'b1, 0, '1, '0); tick();
        set_in(1'b1, 1, '1, '0); tick();
        do_reset();
        set_in(1'b0, 0, '0, 3'b001); tick();
        set_in(1'b0, 0, '0, 3'b010); tick();
        set_in(1'b0, 0, '0, '0);     tick();
        #1 check("t5_quiet", {apu_rvalid_o, apu_busy_o, unit_clk_en_o}, '0);

        // Same-cycle result and new issue on unit 0.
        set_in(1'b1, 0, '1, '0);     tick();
        set_in(1'b1, 0, '1, 3'b001); tick();
        set_in(1'b0, 0, '0, 3'b001); tick();
        drain();

        // Randomised back-to-back traffic.
        for (int c = 0; c < 400; c++) begin
            bit [NU-1:0] ug, urv;
            int unit;
            unit = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, NU-1));
            for (int u = 0; u < NU; u++) begin
                ug[u]  = ($urandom_range(0, 4) != 0);
                urv[u] = pend(u) ? ($urandom_range(0, 4) < 2) : ($urandom_range(0, 19) == 0);
            end
            set_in($urandom_range(0, 3) != 0, unit, ug, urv);
            tick();
        end
        drain();
        check("rand_ops_ge16", 64'(nissue >= 16), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
